mem_arbiter: RTL

Two-port to one-port memory arbiter for the RV32 core. It shares a single unified memory port between the instruction-fetch unit and the load/store unit. Data accesses have fixed priority, with a starvation limit that guarantees fetch progress. Only one transaction is outstanding at a time, and each response is routed back to the requester that owns it.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                     |
// | Brief    : Fetch/LSU to single memory port arbiter, one txn outstanding,   |
// |            LSU priority with a starvation bound for fetch.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [XLEN-1:0]   if_rdata_o,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [XLEN/8-1:0] lsu_be_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    localparam logic       c_OWNER_IF  = 1'b0;
    localparam logic       c_OWNER_LSU = 1'b1;

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [3:0]        r_starve_cnt;
    logic              r_owner;
    logic              r_mem_we;
    logic [XLEN/8-1:0] r_mem_be;
    logic [XLEN-1:0]   r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic              w_starved;
    logic              w_if_win;
    logic              w_lsu_win;

    // Fetch overrides the LSU only once it has lost STARVE_LIMIT grants in a row.
    assign w_starved = (r_starve_cnt == c_STARVE_LIMIT);
    assign w_if_win  = if_req_i && (!lsu_req_i || w_starved);
    assign w_lsu_win = lsu_req_i && !(if_req_i && w_starved);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (if_req_i || lsu_req_i) w_next_state = c_REQ;
            c_REQ:   if (mem_gnt_i)             w_next_state = c_WAIT;
            c_WAIT:  if (mem_rvalid_i)          w_next_state = c_IDLE;
            default:                            w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o     = 1'b0;
        lsu_gnt_o    = 1'b0;
        if_rvalid_o  = 1'b0;
        lsu_rvalid_o = 1'b0;
        mem_req_o    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if_gnt_o  = w_if_win;
                lsu_gnt_o = w_lsu_win;
            end
            c_REQ: begin
                mem_req_o = 1'b1;
            end
            c_WAIT: begin
                if_rvalid_o  = mem_rvalid_i && (r_owner == c_OWNER_IF);
                lsu_rvalid_o = mem_rvalid_i && (r_owner == c_OWNER_LSU);
            end
            default: ;
        endcase
    end

    // Request fields are captured at grant time and held until the next grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner      <= c_OWNER_IF;
            r_starve_cnt <= 4'd0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else if (if_gnt_o) begin
            r_owner      <= c_OWNER_IF;
            r_starve_cnt <= 4'd0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '1;
            r_mem_addr   <= if_addr_i;
            r_mem_wdata  <= '0;
        end else if (lsu_gnt_o) begin
            r_owner      <= c_OWNER_LSU;
            if (!if_req_i) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt < c_STARVE_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            r_mem_we     <= lsu_we_i;
            r_mem_be     <= lsu_be_i;
            r_mem_addr   <= lsu_addr_i;
            r_mem_wdata  <= lsu_wdata_i;
        end
    end

    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign if_rdata_o  = mem_rdata_i;
    assign lsu_rdata_o = mem_rdata_i;

endmodule
`default_nettype wire
